// File: rtl/alu_pkg.sv
// Opcode encoding, default widths, bubble constants and immediate extension shared by the ID/EX stage.
package alu_pkg;

   localparam int DW_DEF = 32;
   localparam int RW_DEF = 5;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_LUI = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_SRA = 4'd8;

   localparam logic [3:0]        OP_BUBBLE   = OP_ADD;
   localparam logic [DW_DEF-1:0] DATA_BUBBLE = '0;

   function automatic logic [DW_DEF-1:0] ext16(input logic [15:0] imm, input logic sext);
      return {{(DW_DEF-16){sext & imm[15]}}, imm};
   endfunction

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   // Opcodes outside the ALU's set travel through but must never write back.
   function automatic logic is_alu_op(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LUI, OP_SLL, OP_SRL, OP_SRA};
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB, index 0 always reads the register file.
module fwd_mux
   import alu_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic [RW-1:0] idx,
   input  logic [DW-1:0] rf_val,
   input  logic          exm_reg_write,
   input  logic [RW-1:0] exm_rd,
   input  logic [DW-1:0] exm_data,
   input  logic          mwb_reg_write,
   input  logic [RW-1:0] mwb_rd,
   input  logic [DW-1:0] mwb_data,
   output logic [DW-1:0] val
);

   always_comb begin
      val = rf_val;
      if (exm_reg_write && (exm_rd == idx) && (idx != '0)) begin
         val = exm_data;
      end else if (mwb_reg_write && (mwb_rd == idx) && (idx != '0)) begin
         val = mwb_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Define ID_EX_FWD_EN to enable operand
// forwarding and operand refresh while stalled; otherwise raw register-file values are used.
module id_ex_stage
   import alu_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [3:0]    in_opcode,
   input  logic [RW-1:0] in_rs_idx,
   input  logic [RW-1:0] in_rt_idx,
   input  logic [RW-1:0] in_rd_idx,
   input  logic [DW-1:0] in_rs_val,
   input  logic [DW-1:0] in_rt_val,
   input  logic [15:0]   in_imm,
   input  logic          in_imm_sext,
   input  logic          in_use_imm,
   input  logic [4:0]    in_shamt,
   input  logic          in_shift_var,
   input  logic          in_reg_write,
   input  logic          stall,
   input  logic          flush,
   input  logic          exm_reg_write,
   input  logic [RW-1:0] exm_rd,
   input  logic [DW-1:0] exm_data,
   input  logic          mwb_reg_write,
   input  logic [RW-1:0] mwb_rd,
   input  logic [DW-1:0] mwb_data,
   output logic          ex_valid,
   output logic [3:0]    alu_opcode,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [RW-1:0] ex_rd,
   output logic          ex_reg_write
);

   function automatic logic [DW-1:0] form_a(input logic [3:0] op, input logic [15:0] imm,
                                            input logic [DW-1:0] rs, input logic [DW-1:0] rt);
      if (op == OP_LUI) begin
         return {imm, {(DW-16){1'b0}}};
      end else if (is_shift(op)) begin
         return rt;
      end else begin
         return rs;
      end
   endfunction

   // Shift amounts are masked to 5 bits here because the ALU shifts by all of b.
   function automatic logic [DW-1:0] form_b(input logic [3:0] op, input logic [15:0] imm,
                                            input logic sext, input logic use_imm,
                                            input logic [4:0] shamt, input logic shift_var,
                                            input logic [DW-1:0] rs, input logic [DW-1:0] rt);
      if (op == OP_LUI) begin
         return DATA_BUBBLE;
      end else if (is_shift(op)) begin
         return {{(DW-5){1'b0}}, (shift_var ? rs[4:0] : shamt)};
      end else if (use_imm) begin
         return ext16(imm, sext);
      end else begin
         return rt;
      end
   endfunction

   logic          valid_q, valid_d;
   logic [3:0]    opcode_q, opcode_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [RW-1:0] rd_q, rd_d;
   logic          reg_write_q, reg_write_d;
   logic [DW-1:0] fwd_rs, fwd_rt;
   logic          load_bubble;

`ifdef ID_EX_FWD_EN
   // Held copy of the instruction so operands can be re-forwarded while stalled.
   logic [RW-1:0] rs_idx_q, rs_idx_d;
   logic [RW-1:0] rt_idx_q, rt_idx_d;
   logic [DW-1:0] rs_val_q, rs_val_d;
   logic [DW-1:0] rt_val_q, rt_val_d;
   logic [15:0]   imm_q, imm_d;
   logic          imm_sext_q, imm_sext_d;
   logic          use_imm_q, use_imm_d;
   logic [4:0]    shamt_q, shamt_d;
   logic          shift_var_q, shift_var_d;
   logic [RW-1:0] sel_rs_idx, sel_rt_idx;
   logic [DW-1:0] sel_rs_val, sel_rt_val;

   assign sel_rs_idx = stall ? rs_idx_q : in_rs_idx;
   assign sel_rt_idx = stall ? rt_idx_q : in_rt_idx;
   assign sel_rs_val = stall ? rs_val_q : in_rs_val;
   assign sel_rt_val = stall ? rt_val_q : in_rt_val;

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
      .idx(sel_rs_idx), .rf_val(sel_rs_val),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
      .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .val(fwd_rs)
   );

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
      .idx(sel_rt_idx), .rf_val(sel_rt_val),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
      .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .val(fwd_rt)
   );
`else
   logic unused_fwd;

   assign fwd_rs     = in_rs_val;
   assign fwd_rt     = in_rt_val;
   assign unused_fwd = ^{exm_reg_write, exm_rd, exm_data, mwb_reg_write, mwb_rd, mwb_data,
                         in_rs_idx, in_rt_idx};
`endif

   assign load_bubble = flush || (!stall && !in_valid);

   always_comb begin
      valid_d     = valid_q;
      opcode_d    = opcode_q;
      a_d         = a_q;
      b_d         = b_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
`ifdef ID_EX_FWD_EN
      rs_idx_d    = rs_idx_q;
      rt_idx_d    = rt_idx_q;
      rs_val_d    = rs_val_q;
      rt_val_d    = rt_val_q;
      imm_d       = imm_q;
      imm_sext_d  = imm_sext_q;
      use_imm_d   = use_imm_q;
      shamt_d     = shamt_q;
      shift_var_d = shift_var_q;
`endif
      if (load_bubble) begin
         valid_d     = 1'b0;
         opcode_d    = OP_BUBBLE;
         a_d         = DATA_BUBBLE;
         b_d         = DATA_BUBBLE;
         rd_d        = '0;
         reg_write_d = 1'b0;
`ifdef ID_EX_FWD_EN
         rs_idx_d    = '0;
         rt_idx_d    = '0;
         rs_val_d    = DATA_BUBBLE;
         rt_val_d    = DATA_BUBBLE;
         imm_d       = '0;
         imm_sext_d  = 1'b0;
         use_imm_d   = 1'b0;
         shamt_d     = '0;
         shift_var_d = 1'b0;
`endif
      end else if (!stall) begin
         valid_d     = 1'b1;
         opcode_d    = in_opcode;
         a_d         = form_a(in_opcode, in_imm, fwd_rs, fwd_rt);
         b_d         = form_b(in_opcode, in_imm, in_imm_sext, in_use_imm, in_shamt,
                              in_shift_var, fwd_rs, fwd_rt);
         rd_d        = in_rd_idx;
         reg_write_d = in_reg_write && (in_rd_idx != '0) && is_alu_op(in_opcode);
`ifdef ID_EX_FWD_EN
         rs_idx_d    = in_rs_idx;
         rt_idx_d    = in_rt_idx;
         rs_val_d    = fwd_rs;
         rt_val_d    = fwd_rt;
         imm_d       = in_imm;
         imm_sext_d  = in_imm_sext;
         use_imm_d   = in_use_imm;
         shamt_d     = in_shamt;
         shift_var_d = in_shift_var;
`endif
      end
`ifdef ID_EX_FWD_EN
      else if (valid_q) begin
         rs_val_d = fwd_rs;
         rt_val_d = fwd_rt;
         a_d      = form_a(opcode_q, imm_q, fwd_rs, fwd_rt);
         b_d      = form_b(opcode_q, imm_q, imm_sext_q, use_imm_q, shamt_q, shift_var_q,
                           fwd_rs, fwd_rt);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         opcode_q    <= OP_BUBBLE;
         a_q         <= DATA_BUBBLE;
         b_q         <= DATA_BUBBLE;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
`ifdef ID_EX_FWD_EN
         rs_idx_q    <= '0;
         rt_idx_q    <= '0;
         rs_val_q    <= DATA_BUBBLE;
         rt_val_q    <= DATA_BUBBLE;
         imm_q       <= '0;
         imm_sext_q  <= 1'b0;
         use_imm_q   <= 1'b0;
         shamt_q     <= '0;
         shift_var_q <= 1'b0;
`endif
      end else begin
         valid_q     <= valid_d;
         opcode_q    <= opcode_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
`ifdef ID_EX_FWD_EN
         rs_idx_q    <= rs_idx_d;
         rt_idx_q    <= rt_idx_d;
         rs_val_q    <= rs_val_d;
         rt_val_q    <= rt_val_d;
         imm_q       <= imm_d;
         imm_sext_q  <= imm_sext_d;
         use_imm_q   <= use_imm_d;
         shamt_q     <= shamt_d;
         shift_var_q <= shift_var_d;
`endif
      end
   end

   assign ex_valid     = valid_q;
   assign alu_opcode   = opcode_q;
   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign ex_rd        = rd_q;
   assign ex_reg_write = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, multi-cycle corner sequences, random vs. reference model.
module tb_id_ex_stage;
   import alu_pkg::*;

`ifdef ID_EX_FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   typedef struct {
      bit          valid;
      logic [3:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsv, rtv;
      logic [15:0] imm;
      bit          sext, use_imm;
      logic [4:0]  shamt;
      bit          shv, rw, stall, flush;
      bit          exm_w;
      logic [4:0]  exm_rd;
      logic [31:0] exm_d;
      bit          mwb_w;
      logic [4:0]  mwb_rd;
      logic [31:0] mwb_d;
   } stim_t;

   typedef struct packed {
      logic        valid;
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      logic        rw;
   } outs_t;

   typedef struct {
      string name;
      stim_t in;
      outs_t exp;
   } vec_t;

   // Model state: visible outputs plus the held instruction and its current operand values.
   typedef struct {
      outs_t       o;
      logic [4:0]  rs, rt;
      logic [31:0] rsv, rtv;
      logic [15:0] imm;
      logic        sext, use_imm, shv;
      logic [4:0]  shamt;
   } mstate_t;

   logic        clk, rst_n;
   logic        in_valid, in_imm_sext, in_use_imm, in_shift_var, in_reg_write, stall, flush;
   logic [3:0]  in_opcode;
   logic [4:0]  in_rs_idx, in_rt_idx, in_rd_idx, in_shamt, exm_rd, mwb_rd;
   logic [31:0] in_rs_val, in_rt_val, exm_data, mwb_data;
   logic [15:0] in_imm;
   logic        exm_reg_write, mwb_reg_write;
   logic        ex_valid, ex_reg_write;
   logic [3:0]  alu_opcode;
   logic [31:0] alu_a, alu_b;
   logic [4:0]  ex_rd;

   int total = 0;
   int bad   = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode),
      .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_imm_sext(in_imm_sext), .in_use_imm(in_use_imm), .in_shamt(in_shamt),
      .in_shift_var(in_shift_var), .in_reg_write(in_reg_write), .stall(stall), .flush(flush),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
      .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .ex_valid(ex_valid), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t instr(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsv,
                                   input logic [4:0] rt, input logic [31:0] rtv, input logic [4:0] rd,
                                   input bit rw, input logic [15:0] imm, input bit sext,
                                   input bit use_imm, input logic [4:0] shamt, input bit shv);
      stim_t s;
      s.valid = 1'b1; s.op = op; s.rs = rs; s.rsv = rsv; s.rt = rt; s.rtv = rtv; s.rd = rd;
      s.rw = rw; s.imm = imm; s.sext = sext; s.use_imm = use_imm; s.shamt = shamt; s.shv = shv;
      s.stall = 1'b0; s.flush = 1'b0;
      s.exm_w = 1'b0; s.exm_rd = 5'd0; s.exm_d = 32'd0;
      s.mwb_w = 1'b0; s.mwb_rd = 5'd0; s.mwb_d = 32'd0;
      return s;
   endfunction

   function automatic outs_t o(input logic v, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input logic rw);
      outs_t r;
      r.valid = v; r.op = op; r.a = a; r.b = b; r.rd = rd; r.rw = rw;
      return r;
   endfunction

   function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] rf, input stim_t s);
      if (FWD_ON && idx != 5'd0 && s.exm_w && s.exm_rd == idx) return s.exm_d;
      if (FWD_ON && idx != 5'd0 && s.mwb_w && s.mwb_rd == idx) return s.mwb_d;
      return rf;
   endfunction

   function automatic mstate_t m_form(input mstate_t m);
      mstate_t r = m;
      if (m.o.op == 4'd5) begin
         r.o.a = {m.imm, 16'h0000};
         r.o.b = 32'd0;
      end else if (m.o.op >= 4'd6 && m.o.op <= 4'd8) begin
         r.o.a = m.rtv;
         r.o.b = m.shv ? (m.rsv % 32) : 32'(m.shamt);
      end else begin
         r.o.a = m.rsv;
         if (!m.use_imm)  r.o.b = m.rtv;
         else if (m.sext) r.o.b = 32'($signed(m.imm));
         else             r.o.b = 32'(m.imm);
      end
      return r;
   endfunction

   function automatic mstate_t m_bubble();
      mstate_t r;
      r.o = o(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      r.rs = 5'd0; r.rt = 5'd0; r.rsv = 32'd0; r.rtv = 32'd0; r.imm = 16'd0;
      r.sext = 1'b0; r.use_imm = 1'b0; r.shv = 1'b0; r.shamt = 5'd0;
      return r;
   endfunction

   function automatic mstate_t m_step(input mstate_t m, input stim_t s);
      mstate_t r = m;
      if (s.flush || (!s.stall && !s.valid)) return m_bubble();
      if (s.stall) begin
         if (FWD_ON && m.o.valid) begin
            r.rsv = m_fwd(m.rs, m.rsv, s);
            r.rtv = m_fwd(m.rt, m.rtv, s);
            r = m_form(r);
         end
         return r;
      end
      r.o.valid = 1'b1; r.o.op = s.op; r.o.rd = s.rd;
      r.o.rw = s.rw && (s.rd != 5'd0) && (s.op <= 4'd8);
      r.rs = s.rs; r.rt = s.rt; r.rsv = m_fwd(s.rs, s.rsv, s); r.rtv = m_fwd(s.rt, s.rtv, s);
      r.imm = s.imm; r.sext = s.sext; r.use_imm = s.use_imm; r.shamt = s.shamt; r.shv = s.shv;
      return m_form(r);
   endfunction

   task automatic apply(input stim_t s);
      in_valid = s.valid; in_opcode = s.op; in_rs_idx = s.rs; in_rt_idx = s.rt; in_rd_idx = s.rd;
      in_rs_val = s.rsv; in_rt_val = s.rtv; in_imm = s.imm; in_imm_sext = s.sext;
      in_use_imm = s.use_imm; in_shamt = s.shamt; in_shift_var = s.shv; in_reg_write = s.rw;
      stall = s.stall; flush = s.flush;
      exm_reg_write = s.exm_w; exm_rd = s.exm_rd; exm_data = s.exm_d;
      mwb_reg_write = s.mwb_w; mwb_rd = s.mwb_rd; mwb_data = s.mwb_d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input outs_t exp);
      outs_t act;
      act = {ex_valid, alu_opcode, alu_a, alu_b, ex_rd, ex_reg_write};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got v=%0d op=%0h a=%h b=%h rd=%0d rw=%0d, want v=%0d op=%0h a=%h b=%h rd=%0d rw=%0d",
                  name, act.valid, act.op, act.a, act.b, act.rd, act.rw,
                  exp.valid, exp.op, exp.a, exp.b, exp.rd, exp.rw);
      end
   endtask

   vec_t    vecs[$];
   stim_t   t, idle;
   outs_t   zero;
   mstate_t m;

   initial begin
      zero = o(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      idle = instr(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0, 16'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      idle.valid = 1'b0;

      // Directed vectors, each loaded with no stall or flush.
      vecs.push_back('{"lui", instr(4'd5, 5'd1, 32'h9, 5'd2, 32'h8, 5'd3, 1'b1, 16'h1234, 1'b0, 1'b0, 5'd0, 1'b0),
                       o(1'b1, 4'd5, 32'h12340000, 32'd0, 5'd3, 1'b1)});
      vecs.push_back('{"sra_var", instr(4'd8, 5'd1, 32'h123, 5'd2, 32'h80000000, 5'd3, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b1),
                       o(1'b1, 4'd8, 32'h80000000, 32'd3, 5'd3, 1'b1)});
      vecs.push_back('{"srl_var_max", instr(4'd7, 5'd1, 32'hFFFFFFFF, 5'd2, 32'h1, 5'd3, 1'b1, 16'h0, 1'b0, 1'b0, 5'd4, 1'b1),
                       o(1'b1, 4'd7, 32'h1, 32'd31, 5'd3, 1'b1)});
      vecs.push_back('{"sll_const", instr(4'd6, 5'd1, 32'h1F, 5'd2, 32'hF0, 5'd3, 1'b1, 16'h0, 1'b0, 1'b0, 5'd7, 1'b0),
                       o(1'b1, 4'd6, 32'hF0, 32'd7, 5'd3, 1'b1)});
      t = instr(4'd0, 5'd2, 32'h11, 5'd0, 32'h22, 5'd4, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      t.exm_w = 1'b1; t.exm_rd = 5'd2; t.exm_d = 32'hAAAA;
      t.mwb_w = 1'b1; t.mwb_rd = 5'd2; t.mwb_d = 32'hBBBB;
      vecs.push_back('{"fwd_exm_wins", t, o(1'b1, 4'd0, FWD_ON ? 32'hAAAA : 32'h11, 32'h22, 5'd4, 1'b1)});
      t = instr(4'd0, 5'd0, 32'h33, 5'd1, 32'h44, 5'd4, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      t.exm_w = 1'b1; t.exm_rd = 5'd0; t.exm_d = 32'hCCCC;
      t.mwb_w = 1'b1; t.mwb_rd = 5'd0; t.mwb_d = 32'hDDDD;
      vecs.push_back('{"fwd_idx0", t, o(1'b1, 4'd0, 32'h33, 32'h44, 5'd4, 1'b1)});
      t = instr(4'd1, 5'd1, 32'h1, 5'd5, 32'h9, 5'd6, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      t.mwb_w = 1'b1; t.mwb_rd = 5'd5; t.mwb_d = 32'h77;
      vecs.push_back('{"fwd_mwb_rt", t, o(1'b1, 4'd1, 32'h1, FWD_ON ? 32'h77 : 32'h9, 5'd6, 1'b1)});
      vecs.push_back('{"imm_sext", instr(4'd4, 5'd1, 32'h10, 5'd2, 32'h5, 5'd3, 1'b1, 16'hFFFC, 1'b1, 1'b1, 5'd0, 1'b0),
                       o(1'b1, 4'd4, 32'h10, 32'hFFFFFFFC, 5'd3, 1'b1)});
      vecs.push_back('{"imm_zext", instr(4'd3, 5'd1, 32'h10, 5'd2, 32'h5, 5'd3, 1'b1, 16'hFFFC, 1'b0, 1'b1, 5'd0, 1'b0),
                       o(1'b1, 4'd3, 32'h10, 32'h0000FFFC, 5'd3, 1'b1)});
      vecs.push_back('{"illegal_op", instr(4'hB, 5'd1, 32'h10, 5'd2, 32'h5, 5'd5, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0),
                       o(1'b1, 4'hB, 32'h10, 32'h5, 5'd5, 1'b0)});
      vecs.push_back('{"rd_zero", instr(4'd2, 5'd1, 32'hF0F0, 5'd2, 32'hFF00, 5'd0, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0),
                       o(1'b1, 4'd2, 32'hF0F0, 32'hFF00, 5'd0, 1'b0)});
      vecs.push_back('{"invalid_slot", idle, zero});

      rst_n = 1'b0;
      apply(idle);
      #12;
      check("reset_state", zero);
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset in the middle of a cycle, then a normal load.
      apply(instr(4'd1, 5'd1, 32'h50, 5'd2, 32'h60, 5'd7, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0));
      step();
      check("pre_reset_load", o(1'b1, 4'd1, 32'h50, 32'h60, 5'd7, 1'b1));
      #2 rst_n = 1'b0;
      #1 check("async_reset", zero);
      @(negedge clk);
      rst_n = 1'b1;
      apply(instr(4'd0, 5'd3, 32'd5, 5'd4, 32'd7, 5'd1, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0));
      step();
      check("add_after_reset", o(1'b1, 4'd0, 32'd5, 32'd7, 5'd1, 1'b1));

      foreach (vecs[i]) begin
         apply(vecs[i].in);
         step();
         check(vecs[i].name, vecs[i].exp);
      end

      // Stall with stale rt=9; the producer retires through MEM/WB on the second stalled edge.
      t = instr(4'd0, 5'd1, 32'h3, 5'd9, 32'h1, 5'd2, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      apply(t);
      step();
      check("stall_load", o(1'b1, 4'd0, 32'h3, 32'h1, 5'd2, 1'b1));
      t = instr(4'd6, 5'd4, 32'hDEAD, 5'd5, 32'hBEEF, 5'd6, 1'b0, 16'h0, 1'b0, 1'b0, 5'd2, 1'b0);
      t.stall = 1'b1;
      apply(t);
      step();
      check("stall_hold", o(1'b1, 4'd0, 32'h3, 32'h1, 5'd2, 1'b1));
      t.mwb_w = 1'b1; t.mwb_rd = 5'd9; t.mwb_d = 32'h55;
      apply(t);
      step();
      check("stall_refresh", o(1'b1, 4'd0, 32'h3, FWD_ON ? 32'h55 : 32'h1, 5'd2, 1'b1));

      // Flush wins over stall; an invalid slot afterwards stays a bubble.
      t.flush = 1'b1;
      apply(t);
      step();
      check("flush_over_stall", zero);
      apply(idle);
      step();
      check("bubble_after_flush", zero);

      // Reset while stalled, then a normal first load.
      apply(instr(4'd4, 5'd1, 32'hAB, 5'd2, 32'hCD, 5'd3, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0));
      step();
      t = idle; t.stall = 1'b1;
      apply(t);
      step();
      check("stalled_before_reset", o(1'b1, 4'd4, 32'hAB, 32'hCD, 5'd3, 1'b1));
      #2 rst_n = 1'b0;
      #1 check("reset_mid_stall", zero);
      @(negedge clk);
      rst_n = 1'b1;
      apply(instr(4'd1, 5'd3, 32'd10, 5'd4, 32'd4, 5'd8, 1'b1, 16'h0, 1'b0, 1'b0, 5'd0, 1'b0));
      step();
      check("load_after_reset", o(1'b1, 4'd1, 32'd10, 32'd4, 5'd8, 1'b1));

      // Random traffic against the reference model, starting from a flushed stage.
      t = idle; t.flush = 1'b1;
      apply(t);
      step();
      m = m_bubble();
      for (int n = 0; n < 400; n++) begin
         t.valid = ($urandom_range(0, 4) != 0);
         t.op = 4'($urandom_range(0, 10));
         t.rs = 5'($urandom_range(0, 3)); t.rt = 5'($urandom_range(0, 3)); t.rd = 5'($urandom_range(0, 3));
         t.rsv = $urandom; t.rtv = $urandom; t.imm = 16'($urandom);
         t.sext = 1'($urandom); t.use_imm = 1'($urandom); t.shamt = 5'($urandom);
         t.shv = 1'($urandom); t.rw = 1'($urandom);
         t.stall = ($urandom_range(0, 3) == 0); t.flush = ($urandom_range(0, 9) == 0);
         t.exm_w = 1'($urandom); t.exm_rd = 5'($urandom_range(0, 3)); t.exm_d = $urandom;
         t.mwb_w = 1'($urandom); t.mwb_rd = 5'($urandom_range(0, 3)); t.mwb_d = $urandom;
         apply(t);
         m = m_step(m, t);
         step();
         check($sformatf("rand%0d", n), m.o);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
